board_streamer: RTL and testbench
=================================

# board_streamer

Reads out a snapshot of the Game of Life board after a generation step and streams it row by row over a valid/ready interface. It sits downstream of the cell array: it consumes the flattened `state_q` outputs of every cell and feeds a display driver or host link. This is the read side of the cell array, while the cell array's `neighbors` inputs are its write side.

## Interface
- `ROWS`, default 8, number of board rows (≥2).
- `COLS`, default 8, number of board columns, equal to the beat width (≥1).
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cells_q`  in  ROWS*COLS  live board state; bit `r*COLS+c` is the cell at row r, column c.
- `start`  in  1  request to snapshot and stream one frame. Sampled only in IDLE.
- `busy`  out  1  high whenever the state is not IDLE.
- `row_data`  out  COLS  current beat payload; bit c is column c.
- `row_addr`  out  $clog2(ROWS)  row index of the current beat.
- `row_valid`  out  1  beat valid.
- `row_ready`  in  1  sink accepts the beat.
- `row_last`  out  1  high on the final beat of a frame.
- `frame_done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- States: IDLE, SEND, and CHECK (CHECK exists only when the macro below is defined).
- **IDLE:**
  - When `start` is high at the clock edge, latch `cells_q` into the shadow register.
  - Set `row_addr` to 0 and go to SEND.
  - The live `cells_q` may change after this edge without affecting the frame.
- **SEND:**
  - `row_valid`=1 and `row_data` = shadow row `row_addr`.
  - A beat transfers on an edge with `row_valid & row_ready`.
  - On a transfer with `row_addr < ROWS-1`, increment `row_addr`.
  - On a transfer with `row_addr == ROWS-1`:
    - If the checksum is compiled in, go to CHECK.
    - Otherwise go to IDLE and assert `frame_done` for the next cycle.
- **Handshake rules:**
  - While `row_valid` is high and `row_ready` is low, `row_data`, `row_addr` and `row_last` hold stable.
  - `row_valid` never drops without a transfer, except on `rst`.
  - `row_ready` may toggle freely and may be high while `row_valid` is low with no effect.
- `start` is ignored while busy. It is not queued.
- A `start` during the `frame_done` cycle is accepted, because the state is already IDLE.
- `row_last`:
  - Without the macro, high when in SEND and `row_addr == ROWS-1`.
  - With the macro, high only in CHECK.
- Reset mid-frame: the frame is aborted immediately. No `frame_done` pulse and no partial beat are produced.

## Timing
- Reset values: state IDLE, `busy`=0, `row_valid`=0, `row_data`=0, `row_addr`=0, `row_last`=0, `frame_done`=0, shadow register all zeros.
- All outputs are registered or decoded directly from state/shadow/`row_addr`. There is no combinational path from `start` or `row_ready` to any output.
- With `start` sampled at edge E0 and `row_ready` held high:
  - Beats occupy cycles 1..ROWS.
  - `frame_done` is high in cycle ROWS+1.
  - `busy` is high in cycles 1..ROWS.
- Throughput is one beat per cycle. Each cycle `row_ready` is low while `row_valid` is high adds exactly one cycle of stall.
- Back-to-back frames: the minimum start-to-start period is ROWS+1 cycles (ROWS+2 with the checksum).

## Configuration
- Macro: `BOARD_STREAMER_CHECKSUM_EN`.
- **Defined:**
  - After row ROWS-1 transfers, the block enters CHECK and emits one extra beat.
  - That beat has `row_data` = XOR of all ROWS shadow rows, `row_addr`=0 and `row_last`=1, under the same valid/ready rules.
  - `frame_done` pulses the cycle after this beat transfers.
- **Undefined:** CHECK and the XOR logic do not exist. A frame is exactly ROWS beats.

## Structure
- Package `board_pkg` holds:
  - the state enum typedef `streamer_state_t` (IDLE, SEND, CHECK);
  - `ROW_IDX_W(rows)`, a `$clog2`-based width helper shared with the cell-array top.
- One sub-module, `row_select`: a parameterised combinational mux that picks row `row_addr` (COLS bits) out of the ROWS*COLS shadow register. The checksum reduction stays inline.

## Test plan
All scenarios use ROWS=4, COLS=4.
- **Basic frame:** reset 2 cycles; `cells_q`=16'h1248, pulse `start`, `row_ready`=1.
  - Beats in cycles 1..4: addr 0..3, data 4'h8, 4'h4, 4'h2, 4'h1.
  - `row_last` on addr 3; `frame_done` in cycle 5.
- **Backpressure:** same frame, with `row_ready` low for 3 cycles during beat addr 1.
  - addr 1 / data 4'h4 stays stable for those 3 cycles.
  - `frame_done` arrives in cycle 8.
- **Snapshot isolation:** change `cells_q` to 16'hFFFF in cycle 1 of a frame started on 16'h1248.
  - All beats still carry 8, 4, 2, 1.
- **Start while busy:** pulse `start` in cycle 2.
  - Exactly one frame is produced.
  - `start` asserted in the `frame_done` cycle launches a second frame beginning the next cycle.
- **Reset mid-frame:** assert `rst` during beat addr 2.
  - The next cycle has `row_valid`=0, `busy`=0, `row_addr`=0, and `frame_done` never pulses.
- **Checksum build (`BOARD_STREAMER_CHECKSUM_EN`):** stream 16'h1248.
  - Beat 5 has data 4'hF, addr 0, `row_last`=1.
  - `row_last` is low on addr 3; `frame_done` in cycle 6.

Source files
------------

// File: rtl/board_pkg.sv
// Shared types and helpers for the board streamer and the cell-array top.
// Provides the streamer FSM state type and the row-index width helper.
package board_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CHECK = 2'd2
    } streamer_state_t;

    function automatic int ROW_IDX_W(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/row_select.sv
// Combinational row mux: picks row i_addr (COLS bits) out of a flattened
// ROWS*COLS board image where bit r*COLS+c is row r, column c.
module row_select
    import board_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int AW   = ROW_IDX_W(ROWS)
) (
    input  logic [ROWS*COLS-1:0] i_rows,
    input  logic [AW-1:0]        i_addr,
    output logic [COLS-1:0]      o_row
);

    logic [COLS-1:0] w_rows [ROWS];

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_split
        assign w_rows[gi] = i_rows[gi*COLS +: COLS];
    end

    // Compare-and-select keeps addresses past ROWS-1 at zero for non-power-of-two boards.
    always_comb begin
        o_row = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (i_addr == AW'(i)) begin
                o_row = w_rows[i];
            end
        end
    end

endmodule

// File: rtl/board_streamer.sv
// Snapshots the Game of Life board on start and streams it row by row over
// valid/ready. Define BOARD_STREAMER_CHECKSUM_EN to append an XOR checksum beat.
module board_streamer
    import board_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ROWS*COLS-1:0]        cells_q,
    input  logic                        start,
    output logic                        busy,
    output logic [COLS-1:0]             row_data,
    output logic [ROW_IDX_W(ROWS)-1:0]  row_addr,
    output logic                        row_valid,
    input  logic                        row_ready,
    output logic                        row_last,
    output logic                        frame_done
);

    localparam int AW = ROW_IDX_W(ROWS);
    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    streamer_state_t       r_state;
    logic [ROWS*COLS-1:0]  r_shadow;
    logic [AW-1:0]         r_addr;
    logic                  r_frame_done;
    logic [COLS-1:0]       w_sel_row;

    row_select #(
        .ROWS (ROWS),
        .COLS (COLS),
        .AW   (AW)
    ) u_row_select (
        .i_rows (r_shadow),
        .i_addr (r_addr),
        .o_row  (w_sel_row)
    );

`ifdef BOARD_STREAMER_CHECKSUM_EN
    logic [COLS-1:0] w_checksum;

    always_comb begin
        w_checksum = '0;
        for (int i = 0; i < ROWS; i++) begin
            w_checksum = w_checksum ^ r_shadow[i*COLS +: COLS];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shadow     <= '0;
            r_addr       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shadow <= cells_q;
                        r_addr   <= '0;
                        r_state  <= SEND;
                    end
                end
                SEND: begin
                    if (row_ready) begin
                        if (r_addr == LAST_ROW) begin
                            r_addr <= '0;
`ifdef BOARD_STREAMER_CHECKSUM_EN
                            r_state <= CHECK;
`else
                            r_state      <= IDLE;
                            r_frame_done <= 1'b1;
`endif
                        end else begin
                            r_addr <= r_addr + AW'(1);
                        end
                    end
                end
`ifdef BOARD_STREAMER_CHECKSUM_EN
                CHECK: begin
                    if (row_ready) begin
                        r_state      <= IDLE;
                        r_frame_done <= 1'b1;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs decode only from registered state, so start/row_ready never reach them combinationally.
    always_comb begin
        busy       = (r_state != IDLE);
        row_addr   = r_addr;
        frame_done = r_frame_done;
        row_valid  = 1'b0;
        row_last   = 1'b0;
        row_data   = '0;
        if (r_state == SEND) begin
            row_valid = 1'b1;
            row_data  = w_sel_row;
`ifndef BOARD_STREAMER_CHECKSUM_EN
            row_last  = (r_addr == LAST_ROW);
`endif
        end
`ifdef BOARD_STREAMER_CHECKSUM_EN
        if (r_state == CHECK) begin
            row_valid = 1'b1;
            row_last  = 1'b1;
            row_data  = w_checksum;
        end
`endif
    end

endmodule

// File: tb/tb_board_streamer.sv
// Directed bench for board_streamer (ROWS=4, COLS=4) with an expected-beat queue.
module tb_board_streamer;

    localparam int ROWS = 4;
    localparam int COLS = 4;
`ifdef BOARD_STREAMER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [ROWS*COLS-1:0]  cells_q = '0;
    logic                  start = 1'b0;
    logic                  busy;
    logic [COLS-1:0]       row_data;
    logic [1:0]            row_addr;
    logic                  row_valid;
    logic                  row_ready = 1'b0;
    logic                  row_last;
    logic                  frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Expected beat: {addr, data, last}
    logic [6:0] exp_q [$];

    board_streamer #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk        (clk),
        .rst        (rst),
        .cells_q    (cells_q),
        .start      (start),
        .busy       (busy),
        .row_data   (row_data),
        .row_addr   (row_addr),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_last   (row_last),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] cells);
        logic [3:0] x;
        logic [3:0] d;
        x = '0;
        for (int r = 0; r < ROWS; r++) begin
            d = cells[r*COLS +: COLS];
            x = x ^ d;
            exp_q.push_back({2'(r), d, (CK == 0) && (r == ROWS - 1)});
        end
        if (CK != 0) exp_q.push_back({2'd0, x, 1'b1});
    endtask

    // Advance one cycle, drive row_ready for the new cycle, and score any beat that will transfer.
    task automatic tick(input logic rdy);
        logic [6:0] e;
        @(posedge clk);
        #1;
        cyc++;
        row_ready = rdy;
        if (row_valid && row_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {25'd0, row_addr, row_data, row_last}, 32'h7f);
            end else begin
                e = exp_q.pop_front();
                check("beat", {25'd0, row_addr, row_data, row_last}, {25'd0, e});
                $display("cycle %0d: beat addr=%0d data=%h last=%0b", cyc, row_addr, row_data, row_last);
            end
        end
    endtask

    task automatic finish_frame(input int exp_cyc);
        for (int i = 0; i < 30; i++) begin
            tick(1'b1);
            if (frame_done) break;
        end
        $display("cycle %0d: frame_done=%0b", cyc, frame_done);
        check("frame_done_cycle", cyc, exp_cyc);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic launch(input logic [15:0] cells);
        cells_q = cells;
        push_frame(cells);
        start = 1'b1;
        cyc = 0;
        tick(1'b1);
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        row_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_valid", row_valid, 0);
        check("rst_data", row_data, 0);
        check("rst_addr", row_addr, 0);
        check("rst_last", row_last, 0);
        check("rst_done", frame_done, 0);

        // Basic frame
        launch(16'h1248);
        check("basic_busy", busy, 1);
        check("basic_valid", row_valid, 1);
        finish_frame(ROWS + CK + 1);
        check("basic_idle", busy, 0);
        tick(1'b1);
        check("done_one_cycle", frame_done, 0);

        // Backpressure for 3 cycles on beat addr 1
        launch(16'h1248);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            check("stall_valid", row_valid, 1);
            check("stall_addr", row_addr, 1);
            check("stall_data", row_data, 4'h4);
            check("stall_last", row_last, 0);
        end
        finish_frame(ROWS + CK + 1 + 3);

        // Snapshot isolation
        launch(16'h1248);
        cells_q = 16'hFFFF;
        finish_frame(ROWS + CK + 1);

        // Start while busy is ignored
        launch(16'h5A3C);
        tick(1'b1);
        start = 1'b1;
        tick(1'b1);
        start = 1'b0;
        finish_frame(ROWS + CK + 1);
        tick(1'b1);
        check("no_queued_start_busy", busy, 0);
        tick(1'b1);
        check("no_queued_start_valid", row_valid, 0);

        // Start during the frame_done cycle launches the next frame immediately
        launch(16'hC3E1);
        finish_frame(ROWS + CK + 1);
        cells_q = 16'h0F96;
        push_frame(16'h0F96);
        start = 1'b1;
        cyc = 0;
        tick(1'b1);
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_addr", row_addr, 0);
        finish_frame(ROWS + CK + 1);

        // Reset mid-frame during beat addr 2
        launch(16'h1248);
        tick(1'b1);
        tick(1'b0);
        check("pre_rst_addr", row_addr, 2);
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        exp_q.delete();
        check("post_rst_valid", row_valid, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_addr", row_addr, 0);
        for (int i = 0; i < ROWS + 2; i++) begin
            tick(1'b1);
            check("post_rst_no_done", frame_done, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
